// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers A/B operand pairs in a small FIFO and streams
// them into a mac_32 unit one pair per cycle, framed into VEC_LEN-pair
// dot-product vectors. Between vectors it drains the MAC pipeline, flags the
// cycle the accumulator holds the full sum and then clears the accumulator.
//
// Build option: define MAC_FEED_RESULT_HOLD_EN to hold result_valid until
// result_ready is seen; without it result_valid is a one-cycle pulse.
//
// Output registers are computed from the current state, so a state visited
// in cycle n determines what the MAC sees in cycle n+1.

module mac_operand_feeder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_a,
  input  logic [DATA_W-1:0]              in_b,
  output logic [DATA_W-1:0]              mac_a,
  output logic [DATA_W-1:0]              mac_b,
  output logic                           mac_reset,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(VEC_LEN+1)-1:0]   vec_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = $clog2(VEC_LEN + 1);

  // IDLE clears the MAC, STREAM issues pairs, DRAIN1/DRAIN2 flush the MAC's
  // product and accumulate stages, HOLD waits for the result consumer.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN1 = 3'd2;
  localparam logic [2:0] S_DRAIN2 = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [DATA_W-1:0] mem_a_r [DEPTH];
  logic [DATA_W-1:0] mem_b_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [VW-1:0]     vec_count_r;
  logic [VW-1:0]     vec_count_s;
  logic [DATA_W-1:0] mac_a_s;
  logic [DATA_W-1:0] mac_b_s;
  logic              mac_reset_s;
  logic              result_valid_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

`ifndef MAC_FEED_RESULT_HOLD_EN
  // result_ready has no effect when results are single-cycle pulses.
  logic unused_result_ready_s;
  assign unused_result_ready_s = result_ready;
`endif

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return ptr + AW'(1'b1);
  endfunction

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;

  assign vec_count = vec_count_r;

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    state_s        = state_r;
    pop_s          = 1'b0;
    mac_a_s        = {DATA_W{1'b0}};
    mac_b_s        = {DATA_W{1'b0}};
    mac_reset_s    = 1'b0;
    result_valid_s = 1'b0;
    vec_count_s    = vec_count_r;
    case (state_r)
      S_IDLE: begin
        mac_reset_s = 1'b1;
        vec_count_s = {VW{1'b0}};
        if (!empty_s) begin
          state_s = S_STREAM;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_STREAM: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          mac_a_s     = mem_a_r[rd_ptr_r];
          mac_b_s     = mem_b_r[rd_ptr_r];
          vec_count_s = vec_count_r + VW'(1'b1);
          if (vec_count_s == VW'(VEC_LEN)) begin
            state_s = S_DRAIN1;
          end else begin
            state_s = S_STREAM;
          end
        end else begin
          // Bubble: zeros go to the MAC and the vector count holds.
          state_s = S_STREAM;
        end
      end
      S_DRAIN1: begin
        state_s = S_DRAIN2;
      end
      S_DRAIN2: begin
        result_valid_s = 1'b1;
`ifdef MAC_FEED_RESULT_HOLD_EN
        state_s = S_HOLD;
`else
        state_s = S_IDLE;
`endif
      end
`ifdef MAC_FEED_RESULT_HOLD_EN
      S_HOLD: begin
        // result_valid is visible in this cycle; zeros keep the sum stable.
        if (result_ready) begin
          mac_reset_s = 1'b1;
          vec_count_s = {VW{1'b0}};
          state_s     = S_IDLE;
        end else begin
          result_valid_s = 1'b1;
          state_s        = S_HOLD;
        end
      end
`endif
      default: begin
        mac_reset_s = 1'b1;
        vec_count_s = {VW{1'b0}};
        state_s     = S_IDLE;
      end
    endcase
  end

  // FIFO storage; payload needs no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_r[wr_ptr_r] <= in_a;
      mem_b_r[wr_ptr_r] <= in_b;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state and registered MAC-facing outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      vec_count_r  <= {VW{1'b0}};
      mac_a        <= {DATA_W{1'b0}};
      mac_b        <= {DATA_W{1'b0}};
      mac_reset    <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      state_r      <= state_s;
      vec_count_r  <= vec_count_s;
      mac_a        <= mac_a_s;
      mac_b        <= mac_b_s;
      mac_reset    <= mac_reset_s;
      result_valid <= result_valid_s;
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder with a behavioural mac_32 model
// (product register followed by an accumulator cleared by mac_reset).
// Directed vectors in a table plus hand-written reset, bubble and
// continuous-stream / FIFO-full sequences.

module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic        mac_reset;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  vec_count;

  mac_operand_feeder #(.DATA_W(32), .DEPTH(4), .VEC_LEN(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_reset    (mac_reset),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .vec_count    (vec_count)
  );

  always #5 clk = ~clk;

  // Reference mac_32: product register, then accumulate; reset clears accum only.
  bit [63:0] prod = 64'd0;
  bit [63:0] acc  = 64'd0;
  always @(posedge clk) begin
    prod <= 64'(mac_a) * 64'(mac_b);
    if (mac_reset) acc <= 64'd0;
    else           acc <= acc + prod;
  end

  // Observation monitor: issue gaps, result events and first pair of a vector.
  int          cyc        = 0;
  int          prev_issue = -1;
  int          gaps[$];
  bit [63:0]   rv_accs[$];
  logic        prev_rv    = 1'b0;
  logic [31:0] first_a    = 32'd0;
  logic [31:0] first_b    = 32'd0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && (mac_a != 32'd0 || mac_b != 32'd0)) begin
      if (prev_issue >= 0 && cyc - prev_issue > 1) gaps.push_back(cyc - prev_issue - 1);
      prev_issue <= cyc;
    end
    if (result_valid && !prev_rv) rv_accs.push_back(acc);
    prev_rv <= result_valid;
    if (vec_count == 4'd1) begin
      first_a <= mac_a;
      first_b <= mac_b;
    end
  end

  int tests = 0;
  int fails = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a pair from a negedge; returns at the negedge after it was taken.
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
      stall_cycles++;
    end
    if (t >= 50) check("push_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_rv(input string name);
    int t = 0;
    while (!result_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check(name, {63'd0, result_valid}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] a0;
    logic [31:0] step;
    logic [31:0] b;
    logic [63:0] exp_acc;
    logic        rr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int t;
    int width;
    int exp_w;
    int exp_gap;
    int exp_stall;
    int base_rv;
    int base_gap;
    logic acc_ok;

    tbl[0] = '{32'd1,          32'd1,      32'd1,          64'd36,                  1'b1};
    tbl[1] = '{32'd7,          32'd0,      32'd16,         64'd896,                 1'b0};
    tbl[2] = '{32'h0000_1000,  32'h1000,   32'd2,          64'd294912,              1'b1};
    tbl[3] = '{32'hFFFF_FFFF,  32'd0,      32'hFFFF_FFFF,  64'hFFFF_FFF0_0000_0008, 1'b1};

    reset_n      = 1'b1;
    in_valid     = 1'b0;
    in_a         = 32'd0;
    in_b         = 32'd0;
    result_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_mac_a",        64'(mac_a), 64'd0);
    check("rst_mac_b",        64'(mac_b), 64'd0);
    check("rst_mac_reset",    {63'd0, mac_reset}, 64'd1);
    check("rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("rst_vec_count",    64'(vec_count), 64'd0);
    check("rst_in_ready",     {63'd0, in_ready}, 64'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted mid-STREAM discards the partial vector.
    base_rv = rv_accs.size();
    for (int i = 0; i < 3; i++) push(32'd9, 32'd9);
    in_valid = 1'b0;
    t = 0;
    while (mac_a == 32'd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_issue_seen", 64'(mac_a), 64'd9);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_mac_a",        64'(mac_a), 64'd0);
    check("mid_rst_mac_b",        64'(mac_b), 64'd0);
    check("mid_rst_mac_reset",    {63'd0, mac_reset}, 64'd1);
    check("mid_rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("mid_rst_vec_count",    64'(vec_count), 64'd0);
    check("mid_rst_in_ready",     {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("mid_rst_no_result", 64'(rv_accs.size() - base_rv), 64'd0);

    // Table-driven vectors.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      result_ready = tbl[k].rr;
`ifdef MAC_FEED_RESULT_HOLD_EN
      exp_w = tbl[k].rr ? 1 : 6;
`else
      exp_w = 1;
`endif
      for (int i = 0; i < 8; i++) push(tbl[k].a0 + tbl[k].step * 32'(i), tbl[k].b);
      in_valid = 1'b0;
      wait_rv("vec_rv_timeout");
      check("vec_count_at_result", 64'(vec_count), 64'd8);
      check("vec_accum", acc, tbl[k].exp_acc);
      width  = 0;
      acc_ok = 1'b1;
      do begin
        if (acc !== tbl[k].exp_acc) acc_ok = 1'b0;
        width++;
        if (width == 6 && !tbl[k].rr) result_ready = 1'b1;
        @(negedge clk);
      end while (result_valid && width < 20);
      check("vec_accum_stable", {63'd0, acc_ok}, 64'd1);
      check("vec_result_width", 64'(width), 64'(exp_w));
      check("vec_mac_reset_after", {63'd0, mac_reset}, 64'd1);
      check("vec_count_cleared", 64'(vec_count), 64'd0);
      check("vec_first_a", 64'(first_a), 64'(tbl[k].a0));
      check("vec_first_b", 64'(first_b), 64'(tbl[k].b));
      result_ready = 1'b1;
      repeat (5) @(negedge clk);
    end

    // Bubbles: four pairs, upstream goes quiet, four more pairs.
    for (int i = 0; i < 4; i++) push(32'd5, 32'd5);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bubble_vec_count_a", 64'(vec_count), 64'd4);
    check("bubble_zero_a",      64'(mac_a), 64'd0);
    repeat (2) @(negedge clk);
    check("bubble_vec_count_b", 64'(vec_count), 64'd4);
    check("bubble_zero_b",      64'(mac_b), 64'd0);
    for (int i = 0; i < 4; i++) push(32'd5, 32'd5);
    in_valid = 1'b0;
    wait_rv("bubble_rv_timeout");
    check("bubble_accum", acc, 64'd200);
    repeat (8) @(negedge clk);

    // Continuous stream of 16 pairs: two vectors, FIFO fills while draining.
`ifdef MAC_FEED_RESULT_HOLD_EN
    exp_gap   = 4;
    exp_stall = 3;
`else
    exp_gap   = 3;
    exp_stall = 2;
`endif
    #1;
    base_rv      = rv_accs.size();
    base_gap     = gaps.size();
    stall_cycles = 0;
    for (int i = 0; i < 16; i++) push(32'd2, 32'd3);
    in_valid = 1'b0;
    t = 0;
    while (rv_accs.size() - base_rv < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #1;
    check("cont_result_count", 64'(rv_accs.size() - base_rv), 64'd2);
    if (rv_accs.size() - base_rv >= 2) begin
      check("cont_accum_0", rv_accs[base_rv],     64'd48);
      check("cont_accum_1", rv_accs[base_rv + 1], 64'd48);
    end
    check("cont_gap_count", 64'(gaps.size() - base_gap), 64'd2);
    if (gaps.size() > base_gap) check("cont_gap_len", 64'(gaps[gaps.size() - 1]), 64'(exp_gap));
    check("fifo_full_stalls", 64'(stall_cycles), 64'(exp_stall));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
